cordic_iter_ctrl: RTL and testbench
===================================

Name: cordic_iter_ctrl

Overview:
- Iterative CORDIC sequencer, directly upstream of the CORDIC X/Y/angle stages.
- Each iteration it:
  - holds the current x_i, y_i, z_i;
  - produces y_i·2^-i and x_i·2^-i by FP32 exponent decrement;
  - produces atan(2^-i) and the rotation direction;
  - strobes the stages, then captures their results as the next iteration's operands.
- Wraps the combinational and pipelined stages into a start/done rotation engine.

Parameters:
- N_ITER, 16, number of CORDIC iterations (1..24).
- STAGE_LAT, 1, cycles from stage_valid to valid x_next/y_next/z_next (1..8).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin rotation; sampled only in IDLE.
- x0  in  32  FP32 initial x.
- y0  in  32  FP32 initial y.
- z0  in  32  FP32 initial angle, radians.
- stage_x  out  32  current x_i.
- stage_y  out  32  current y_i.
- stage_z  out  32  current z_i.
- stage_x_shift  out  32  x_i·2^-i.
- stage_y_shift  out  32  y_i·2^-i.
- stage_atan  out  32  FP32 atan(2^-i).
- stage_dir  out  1  sign bit of z_i; 1 = z_i negative.
- stage_valid  out  1  one-cycle strobe; operands are valid.
- x_next  in  32  result from X stage.
- y_next  in  32  result from Y stage.
- z_next  in  32  result from angle stage.
- iter  out  5  current iteration index i.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse; x_out/y_out/z_out valid.
- x_out  out  32  final x, held until next start.
- y_out  out  32  final y, held until next start.
- z_out  out  32  final z, held until next start.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All data outputs, iter, busy, done and stage_valid are 0.
  - Reset mid-rotation aborts immediately; no done pulse; outputs are zero on the next cycle.
- FSM states: IDLE, ISSUE, WAIT, UPDATE, FIN.
- IDLE:
  - start=1 latches x0/y0/z0 into the x/y/z registers and sets iter=0 and busy=1.
  - Next state is ISSUE.
- ISSUE:
  - stage_valid=1 for exactly this cycle; load wait counter with STAGE_LAT-1.
  - Next state is WAIT.
- WAIT:
  - Count down; stage_* outputs are held stable.
  - When the count reaches 0, go to UPDATE.
  - Net effect: capture happens on the edge ending cycle c+STAGE_LAT, where c is the ISSUE cycle.
- UPDATE:
  - Capture x_next/y_next/z_next into the registers.
  - If iter==N_ITER-1, go to FIN; otherwise iter++ and go to ISSUE.
- FIN:
  - done=1 for one cycle; x_out/y_out/z_out are loaded from the registers.
  - busy drops in the same cycle; next state is IDLE.
- Rotation latency: from the start edge to the done cycle is N_ITER·(STAGE_LAT+2)+1 cycles.
- start while busy is ignored; start in the FIN cycle is ignored.
- Back-to-back rotations: start may be accepted in the first IDLE cycle after FIN.
- Exponent shift of operand v by i (combinational from the registers):
  - e = v[30:23].
  - e==255 (Inf/NaN): pass v unchanged.
  - e==0 (zero/denormal): output {v[31], 31'b0}.
  - e<=i: underflow; output {v[31], 31'b0}.
  - Otherwise: output {v[31], e-i, v[22:0]}.
- stage_atan is the table entry for iter (combinational ROM).
- stage_dir = stage_z[31]; -0.0 counts as negative, matching the stage d convention.
- x_out/y_out/z_out are held until the next FIN.

Decomposition:
- Shared package cordic_pkg:
  - FP32 field widths and positions;
  - ATAN_TABLE[0:23] FP32 constants (0x3F490FDB, 0x3EED6338, 0x3E7ADBB0, ...);
  - FSM state enum;
  - max-iteration constant 24.
- One sub-module, fp_exp_shift: operand and shift amount in, scaled FP32 out; instantiated twice (x and y).

Test Plan:
- Reset then idle -> all outputs 0, busy=0; start during rst=1 -> no activity.
- Shift check: x=0x3F800000 (1.0), iter=3 -> stage_x_shift=0x3E000000. x=0x00400000 -> 0x00000000. x=0x7F800000 -> unchanged. x=0xBC800000 (e=121) at i=122 -> 0x80000000.
- Full rotation, N_ITER=4, STAGE_LAT=1, stub stages returning operand+1 pattern:
  - stage_valid at cycles 1,4,7,10; done at cycle 13;
  - iter sequence 0..3;
  - stage_atan matches the table for i=0..2.
- z0=0xBF000000 (-0.5) -> stage_dir=1 in first ISSUE; z0=0x3F000000 -> stage_dir=0.
- start pulsed while busy and in FIN -> ignored, single done; start the cycle after FIN -> second rotation accepted.
- rst asserted in WAIT of iteration 2 -> next cycle IDLE, busy=0, no done; a subsequent start runs normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared FP32 field layout, arctangent table and sequencer states for the CORDIC engine
package cordic_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_LSB  = 23;
    localparam int SIGN_BIT = 31;
    localparam int MAX_ITER = 24;
    localparam int ITER_W   = 5;
    localparam int CNT_W    = 3;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_UPDATE,
        S_FIN
    } state_t;

    // atan(2^-i) rounded to nearest FP32; from i=12 on the value equals 2^-i
    localparam logic [FP_W-1:0] ATAN_TABLE [0:MAX_ITER-1] = '{
        32'h3F490FDB, 32'h3EED6338, 32'h3E7ADBB0, 32'h3DFEADD5,
        32'h3D7FAADE, 32'h3CFFEAAE, 32'h3C7FFAAB, 32'h3BFFFEAB,
        32'h3B7FFFAB, 32'h3AFFFFEB, 32'h3A7FFFFB, 32'h39FFFFFF,
        32'h39800000, 32'h39000000, 32'h38800000, 32'h38000000,
        32'h37800000, 32'h37000000, 32'h36800000, 32'h36000000,
        32'h35800000, 32'h35000000, 32'h34800000, 32'h34000000
    };

    function automatic logic [FP_W-1:0] atan_rom(input logic [ITER_W-1:0] i);
        return (i < ITER_W'(MAX_ITER)) ? ATAN_TABLE[i] : '0;
    endfunction

endpackage

// File: rtl/cordic_iter_ctrl_fp_exp_shift.sv
// rtl/cordic_iter_ctrl_fp_exp_shift.sv - scales an FP32 operand by 2^-shamt through exponent decrement
module fp_exp_shift
    import cordic_pkg::*;
(
    input  logic [FP_W-1:0]  operand,
    input  logic [EXP_W-1:0] shamt,
    output logic [FP_W-1:0]  result
);

    logic [EXP_W-1:0] exp_f;

    // Denormals and underflow flush to a signed zero; Inf/NaN pass through untouched
    always_comb begin
        exp_f = operand[EXP_LSB +: EXP_W];
        if (exp_f == EXP_MAX) begin
            result = operand;
        end else if ((exp_f == '0) || (exp_f <= shamt)) begin
            result = {operand[SIGN_BIT], {(FP_W-1){1'b0}}};
        end else begin
            result = {operand[SIGN_BIT], exp_f - shamt, operand[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// rtl/cordic_iter_ctrl.sv - iterative CORDIC sequencer that feeds the X/Y/angle stages and collects their results
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int N_ITER    = 16,
    parameter int STAGE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FP_W-1:0]   x0,
    input  logic [FP_W-1:0]   y0,
    input  logic [FP_W-1:0]   z0,
    output logic [FP_W-1:0]   stage_x,
    output logic [FP_W-1:0]   stage_y,
    output logic [FP_W-1:0]   stage_z,
    output logic [FP_W-1:0]   stage_x_shift,
    output logic [FP_W-1:0]   stage_y_shift,
    output logic [FP_W-1:0]   stage_atan,
    output logic              stage_dir,
    output logic              stage_valid,
    input  logic [FP_W-1:0]   x_next,
    input  logic [FP_W-1:0]   y_next,
    input  logic [FP_W-1:0]   z_next,
    output logic [ITER_W-1:0] iter,
    output logic              busy,
    output logic              done,
    output logic [FP_W-1:0]   x_out,
    output logic [FP_W-1:0]   y_out,
    output logic [FP_W-1:0]   z_out
);

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(STAGE_LAT - 1);

    state_t            state_q, state_d;
    logic [FP_W-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
    logic [FP_W-1:0]   x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        z_out_d = z_out_q;
        iter_d  = iter_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x0;
                    y_d     = y0;
                    z_d     = z0;
                    iter_d  = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = WAIT_LOAD;
                state_d = S_WAIT;
            end
            // Results are valid STAGE_LAT cycles after the strobe, i.e. in the last WAIT cycle
            S_WAIT: begin
                if (cnt_q == '0) begin
                    x_d     = x_next;
                    y_d     = y_next;
                    z_d     = z_next;
                    state_d = S_UPDATE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_UPDATE: begin
                if (iter_q == LAST_ITER) begin
                    x_out_d = x_q;
                    y_out_d = y_q;
                    z_out_d = z_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    iter_d  = iter_q + 1'b1;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
            iter_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            z_out_q <= z_out_d;
            iter_q  <= iter_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    fp_exp_shift u_x_shift (
        .operand (x_q),
        .shamt   ({{(EXP_W-ITER_W){1'b0}}, iter_q}),
        .result  (stage_x_shift)
    );

    fp_exp_shift u_y_shift (
        .operand (y_q),
        .shamt   ({{(EXP_W-ITER_W){1'b0}}, iter_q}),
        .result  (stage_y_shift)
    );

    // The table is gated by busy so an idle engine presents all-zero operands
    assign stage_atan  = busy_q ? atan_rom(iter_q) : '0;
    assign stage_x     = x_q;
    assign stage_y     = y_q;
    assign stage_z     = z_q;
    assign stage_dir   = z_q[SIGN_BIT];
    assign stage_valid = valid_q;
    assign iter        = iter_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign x_out       = x_out_q;
    assign y_out       = y_out_q;
    assign z_out       = z_out_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb/tb_cordic_iter_ctrl.sv - directed self-checking bench for cordic_iter_ctrl with stub stages
module tb_cordic_iter_ctrl;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] x0, y0, z0;
    logic [31:0] stage_x, stage_y, stage_z, stage_x_shift, stage_y_shift, stage_atan;
    logic        stage_dir, stage_valid, busy, done;
    logic [31:0] x_next, y_next, z_next, x_out, y_out, z_out;
    logic [4:0]  iter;

    logic [31:0] sh_in, sh_out;
    logic [7:0]  sh_amt;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;

    logic [31:0] atan_ref [0:3] = '{32'h3F490FDB, 32'h3EED6338, 32'h3E7ADBB0, 32'h3DFEADD5};

    always #5 clk = ~clk;

    cordic_iter_ctrl #(.N_ITER(4), .STAGE_LAT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .x0            (x0),
        .y0            (y0),
        .z0            (z0),
        .stage_x       (stage_x),
        .stage_y       (stage_y),
        .stage_z       (stage_z),
        .stage_x_shift (stage_x_shift),
        .stage_y_shift (stage_y_shift),
        .stage_atan    (stage_atan),
        .stage_dir     (stage_dir),
        .stage_valid   (stage_valid),
        .x_next        (x_next),
        .y_next        (y_next),
        .z_next        (z_next),
        .iter          (iter),
        .busy          (busy),
        .done          (done),
        .x_out         (x_out),
        .y_out         (y_out),
        .z_out         (z_out)
    );

    fp_exp_shift u_shift (
        .operand (sh_in),
        .shamt   (sh_amt),
        .result  (sh_out)
    );

    // One-cycle stub stages: distinct increments per path so swapped captures show up
    always @(posedge clk) begin
        if (stage_valid) begin
            x_next <= stage_x + 32'd1;
            y_next <= stage_y + 32'd2;
            z_next <= stage_z + 32'd3;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic shift_vec(input logic [31:0] v, input logic [7:0] s, input logic [31:0] exp);
        sh_in  = v;
        sh_amt = s;
        #1;
        chk("shift", sh_out, exp);
    endtask

    task automatic full_rot(input logic [31:0] xa, input logic [31:0] ya, input logic [31:0] za);
        int          it;
        logic        issue;
        logic [31:0] ex, ey;
        x0    = xa;
        y0    = ya;
        z0    = za;
        start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            it    = (k <= 12) ? (k - 1) / 3 : 3;
            issue = (k % 3 == 1) && (k <= 10);
            chk("valid", stage_valid, issue);
            chk("done", done, k == 13);
            chk("busy", busy, k <= 12);
            chk("iter", iter, it);
            if (issue) begin
                ex = xa + it;
                ey = ya + 2 * it;
                chk("stage_x", stage_x, ex);
                chk("stage_y", stage_y, ey);
                chk("stage_z", stage_z, za + 3 * it);
                chk("x_shift", stage_x_shift, {ex[31], ex[30:23] - 8'(it), ex[22:0]});
                chk("y_shift", stage_y_shift, {ey[31], ey[30:23] - 8'(it), ey[22:0]});
                chk("atan", stage_atan, atan_ref[it]);
                chk("dir", stage_dir, za[31]);
            end
            if (k == 13) begin
                chk("x_out", x_out, xa + 32'd4);
                chk("y_out", y_out, ya + 32'd8);
                chk("z_out", z_out, za + 32'd12);
            end
        end
    endtask

    initial begin
        int base;
        bit found;
        rst = 1'b1;
        start = 1'b1;
        x0 = 32'h3F800000;
        y0 = 32'h40000000;
        z0 = 32'hBF000000;

        shift_vec(32'h3F800000, 8'd3,   32'h3E000000);
        shift_vec(32'h00400000, 8'd0,   32'h00000000);
        shift_vec(32'h7F800000, 8'd5,   32'h7F800000);
        shift_vec(32'hBC800000, 8'd122, 32'h80000000);
        shift_vec(32'hBC800000, 8'd120, 32'h80800000);
        shift_vec(32'h3F800000, 8'd127, 32'h00000000);

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", stage_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_iter", iter, 0);
        chk("rst_stage_x", stage_x, 0);
        chk("rst_atan", stage_atan, 0);
        chk("rst_x_out", x_out, 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", stage_valid, 0);

        full_rot(32'h3F800000, 32'h40000000, 32'hBF000000);
        chk("done_count_1", done_cnt, 1);

        // Start held high through the whole rotation and FIN, then taken again right after
        base  = done_cnt;
        x0    = 32'h3F800000;
        y0    = 32'h40000000;
        z0    = 32'h3F000000;
        start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("dir_pos_valid", stage_valid, 1);
                chk("dir_pos", stage_dir, 0);
            end
            if (k == 13) chk("held_done", done, 1);
            if (k == 14) begin
                chk("after_fin_busy", busy, 0);
                chk("after_fin_valid", stage_valid, 0);
                z0 = 32'hBF000000;
            end
            if (k == 15) begin
                chk("b2b_valid", stage_valid, 1);
                chk("b2b_busy", busy, 1);
                chk("b2b_iter", iter, 0);
                chk("b2b_z", stage_z, 32'hBF000000);
                chk("b2b_dir", stage_dir, 1);
                start = 1'b0;
            end
        end
        chk("single_done", done_cnt - base, 1);

        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            if (iter == 5'd2 && stage_valid) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_iter2", found, 1);
        @(negedge clk);
        chk("in_wait", stage_valid, 0);
        base = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_valid", stage_valid, 0);
        chk("abort_iter", iter, 0);
        chk("abort_stage_x", stage_x, 0);
        chk("abort_x_shift", stage_x_shift, 0);
        chk("abort_atan", stage_atan, 0);
        chk("abort_x_out", x_out, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt - base, 0);

        full_rot(32'hC0400000, 32'h3E800000, 32'h3F000000);
        chk("done_count_final", done_cnt - base, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
